// File: rtl/axi_win_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_win_trace_pkg : shared types for the AXI window trace monitor    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_win_trace_pkg;

  localparam int WIN_IDX_W  = 3;
  localparam int EVT_ADDR_W = 64;
  localparam int EVT_TS_W   = 32;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_ARMED   = 2'd1,
    WD_EXPIRED = 2'd2
  } wd_state_e;

  // Layout of one trace entry for the default 64-bit address / 32-bit counter build.
  typedef struct packed {
    logic                  is_write;
    logic [WIN_IDX_W-1:0]  win_idx;
    logic [EVT_ADDR_W-1:0] addr;
    logic [EVT_TS_W-1:0]   timestamp;
  } evt_t;

endpackage
`default_nettype wire

// File: rtl/axi_win_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_win_trace_fifo : dual-push, single-pop synchronous event FIFO    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_win_trace_fifo
  import axi_win_trace_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_a,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     push_b,
  input  logic [WIDTH-1:0]         data_b,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_pop;
  logic             do_b;

  // push_b is only ever the second entry of a pair; the caller guarantees room.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_b    = push_a && push_b;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_a) mem_d[wptr_q] = data_a;
      if (do_b)   mem_d[wptr_q + PTR_W'(1)] = data_b;
      wptr_d  = wptr_q + PTR_W'(push_a) + PTR_W'(do_b);
      rptr_d  = rptr_q + PTR_W'(do_pop);
      count_d = count_q + (PTR_W+1)'(push_a) + (PTR_W+1)'(do_b) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign head  = mem_q[rptr_q];
  assign free  = (PTR_W+1)'(DEPTH) - count_q;

endmodule
`default_nettype wire

// File: rtl/axi_win_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_win_trace_monitor : AXI AR/AW window hit counters, retire count, |
// | retire watchdog and timestamped hit-event FIFO.          rev 1.0     |
// +----------------------------------------------------------------------+
module axi_win_trace_monitor
  import axi_win_trace_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int NUM_WIN    = 4,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TO_W       = 32
) (
  input  logic                        io_axiClk,
  input  logic                        io_asyncResetn,
  input  logic                        ar_valid,
  input  logic                        ar_ready,
  input  logic [ADDR_W-1:0]           ar_addr,
  input  logic                        aw_valid,
  input  logic                        aw_ready,
  input  logic [ADDR_W-1:0]           aw_addr,
  input  logic                        retire,
  input  logic [NUM_WIN-1:0]          win_en,
  input  logic [NUM_WIN*ADDR_W-1:0]   win_base,
  input  logic [NUM_WIN*ADDR_W-1:0]   win_limit,
  input  logic                        clr,
  input  logic [TO_W-1:0]             to_limit,
  output logic [CNT_W-1:0]            instr_cnt,
  output logic [NUM_WIN*CNT_W-1:0]    rd_cnt,
  output logic [NUM_WIN*CNT_W-1:0]    wr_cnt,
  output logic                        timeout,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [1+WIN_IDX_W+ADDR_W+CNT_W-1:0] evt_data,
  output logic [CNT_W-1:0]            evt_drop
);

  localparam int EVT_W  = 1 + WIN_IDX_W + ADDR_W + CNT_W;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_WIN-1:0]   ar_hit, aw_hit;
  logic [WIN_IDX_W-1:0] ar_idx, aw_idx;
  logic                 ar_any, aw_any;
  logic                 ar_evt, aw_evt;

  logic [CNT_W-1:0] ts_q, ts_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] rd_q [NUM_WIN];
  logic [CNT_W-1:0] rd_d [NUM_WIN];
  logic [CNT_W-1:0] wr_q [NUM_WIN];
  logic [CNT_W-1:0] wr_d [NUM_WIN];

  wd_state_e        wd_q, wd_d;
  logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic [FCNT_W-1:0] fifo_free;
  logic [FCNT_W:0]   free_eff;
  logic [FCNT_W:0]   aw_need;
  logic              pop;
  logic              ar_ok, aw_ok;
  logic [1:0]        n_drop;
  logic [CNT_W:0]    drop_sum;
  logic              push_a, push_b;
  logic [EVT_W-1:0]  ar_data, aw_data, push_a_data, fifo_head;
  logic              fifo_valid;

  generate
    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
      logic [ADDR_W-1:0] base, limit;
      logic              win_ok;
      assign base   = win_base[i*ADDR_W +: ADDR_W];
      assign limit  = win_limit[i*ADDR_W +: ADDR_W];
      assign win_ok = win_en[i] && (base < limit);
      assign ar_hit[i] = win_ok && (ar_addr >= base) && (ar_addr < limit);
      assign aw_hit[i] = win_ok && (aw_addr >= base) && (aw_addr < limit);
      assign rd_cnt[i*CNT_W +: CNT_W] = rd_q[i];
      assign wr_cnt[i*CNT_W +: CNT_W] = wr_q[i];
    end
  endgenerate

  // Scan downward so the lowest matching window index is the one kept.
  always_comb begin
    ar_idx = '0;
    aw_idx = '0;
    ar_any = 1'b0;
    aw_any = 1'b0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (ar_hit[i]) begin
        ar_idx = WIN_IDX_W'(i);
        ar_any = 1'b1;
      end
      if (aw_hit[i]) begin
        aw_idx = WIN_IDX_W'(i);
        aw_any = 1'b1;
      end
    end
  end

  assign ar_evt  = ar_valid && ar_ready && ar_any;
  assign aw_evt  = aw_valid && aw_ready && aw_any;
  assign ar_data = {1'b0, ar_idx, ar_addr, ts_q};
  assign aw_data = {1'b1, aw_idx, aw_addr, ts_q};

  // A pop in this cycle frees a slot the incoming pushes may use.
  assign pop      = fifo_valid && evt_ready;
  assign free_eff = {1'b0, fifo_free} + (FCNT_W+1)'(pop);
  assign ar_ok    = ar_evt && (free_eff >= (FCNT_W+1)'(1));
  assign aw_need  = ar_ok ? (FCNT_W+1)'(2) : (FCNT_W+1)'(1);
  assign aw_ok    = aw_evt && (free_eff >= aw_need);
  assign n_drop   = 2'(ar_evt && !ar_ok) + 2'(aw_evt && !aw_ok);
  assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);

  assign push_a      = !clr && (ar_ok || aw_ok);
  assign push_b      = !clr && ar_ok && aw_ok;
  assign push_a_data = ar_ok ? ar_data : aw_data;

  always_comb begin
    ts_d    = clr ? '0 : ts_q + CNT_W'(1);
    instr_d = instr_q;
    drop_d  = drop_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (clr) begin
      instr_d = '0;
      drop_d  = '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        rd_d[i] = '0;
        wr_d[i] = '0;
      end
    end else begin
      if (retire && (instr_q != '1)) instr_d = instr_q + CNT_W'(1);
      drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      for (int i = 0; i < NUM_WIN; i++) begin
        if (ar_evt && (ar_idx == WIN_IDX_W'(i)) && (rd_q[i] != '1)) rd_d[i] = rd_q[i] + CNT_W'(1);
        if (aw_evt && (aw_idx == WIN_IDX_W'(i)) && (wr_q[i] != '1)) wr_d[i] = wr_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    wd_d     = wd_q;
    wd_cnt_d = wd_cnt_q;
    if (clr) begin
      wd_cnt_d = '0;
      wd_d     = (to_limit == '0) ? WD_IDLE : WD_ARMED;
    end else begin
      case (wd_q)
        WD_IDLE: begin
          wd_cnt_d = '0;
          if (to_limit != '0) wd_d = WD_ARMED;
        end
        WD_ARMED: begin
          if (to_limit == '0) begin
            wd_d     = WD_IDLE;
            wd_cnt_d = '0;
          end else if (retire) begin
            wd_cnt_d = '0;
          end else if (wd_cnt_q >= to_limit - TO_W'(1)) begin
            // >= rather than == so a limit lowered below the count still expires.
            wd_d     = WD_EXPIRED;
            wd_cnt_d = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
          end
        end
        WD_EXPIRED: wd_cnt_d = '0;
        default: begin
          wd_d     = WD_IDLE;
          wd_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      ts_q     <= '0;
      instr_q  <= '0;
      drop_q   <= '0;
      wd_q     <= WD_IDLE;
      wd_cnt_q <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        rd_q[i] <= '0;
        wr_q[i] <= '0;
      end
    end else begin
      ts_q     <= ts_d;
      instr_q  <= instr_d;
      drop_q   <= drop_d;
      wd_q     <= wd_d;
      wd_cnt_q <= wd_cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  axi_win_trace_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (io_axiClk),
    .rst_n  (io_asyncResetn),
    .flush  (clr),
    .push_a (push_a),
    .data_a (push_a_data),
    .push_b (push_b),
    .data_b (aw_data),
    .pop    (pop),
    .valid  (fifo_valid),
    .head   (fifo_head),
    .free   (fifo_free)
  );

  assign instr_cnt = instr_q;
  assign evt_drop  = drop_q;
  assign timeout   = (wd_q == WD_EXPIRED);
  assign evt_valid = fifo_valid;
  assign evt_data  = fifo_valid ? fifo_head : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_win_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_win_trace_monitor : scoreboard bench for axi_win_trace_monitor|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi_win_trace_monitor;
  import axi_win_trace_pkg::*;

  localparam int ADDR_W = 64;
  localparam int NUM_WIN = 4;
  localparam int CNT_W = 32;
  localparam int EW = 1 + 3 + ADDR_W + CNT_W;
  localparam int S_CNT_W = 8;
  localparam int S_EW = 1 + 3 + ADDR_W + S_CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ar_valid = 0, ar_ready = 1, aw_valid = 0, aw_ready = 1;
  logic [ADDR_W-1:0] ar_addr = '0, aw_addr = '0;
  logic retire = 0, clr = 0, evt_ready = 1;
  logic [NUM_WIN-1:0] win_en = '0;
  logic [NUM_WIN*ADDR_W-1:0] win_base = '0, win_limit = '0;
  logic [31:0] to_limit = '0;

  logic [CNT_W-1:0] instr_cnt, evt_drop;
  logic [NUM_WIN*CNT_W-1:0] rd_cnt, wr_cnt;
  logic timeout, evt_valid;
  logic [EW-1:0] evt_data;

  logic [S_CNT_W-1:0] s_instr, s_drop;
  logic [NUM_WIN*S_CNT_W-1:0] s_rd, s_wr;
  logic s_timeout, s_valid;
  logic [S_EW-1:0] s_data;

  int n_checks = 0;
  int n_fail = 0;
  int n_pops = 0;
  logic [EW-1:0] sb[$];
  logic [CNT_W-1:0] ts_model;

  always #5 clk = ~clk;

  axi_win_trace_monitor #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .CNT_W(CNT_W),
                          .FIFO_DEPTH(8), .TO_W(32)) u_dut (
    .io_axiClk(clk), .io_asyncResetn(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .retire(retire), .win_en(win_en), .win_base(win_base), .win_limit(win_limit),
    .clr(clr), .to_limit(to_limit), .instr_cnt(instr_cnt), .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt), .timeout(timeout), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .evt_drop(evt_drop));

  axi_win_trace_monitor #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .CNT_W(S_CNT_W),
                          .FIFO_DEPTH(8), .TO_W(32)) u_small (
    .io_axiClk(clk), .io_asyncResetn(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .retire(retire), .win_en(win_en), .win_base(win_base), .win_limit(win_limit),
    .clr(clr), .to_limit(to_limit), .instr_cnt(s_instr), .rd_cnt(s_rd),
    .wr_cnt(s_wr), .timeout(s_timeout), .evt_valid(s_valid),
    .evt_ready(evt_ready), .evt_data(s_data), .evt_drop(s_drop));

  // Reference timestamp: free-running, cleared by clr and reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= '0;
    else if (clr) ts_model <= '0;
    else ts_model <= ts_model + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic w, input logic [2:0] idx,
                                       input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] ts);
    evt_t e;
    e.is_write = w;
    e.win_idx = idx;
    e.addr = a;
    e.timestamp = ts;
    return e;
  endfunction

  // Monitor: every accepted event is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_evt: got %0h expected none", evt_data);
      end else begin
        chk("evt_data", evt_data, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int i, input logic en, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] l);
    win_en[i] = en;
    win_base[i*ADDR_W +: ADDR_W] = b;
    win_limit[i*ADDR_W +: ADDR_W] = l;
  endtask

  task automatic do_clr();
    step(); clr = 1;
    step(); clr = 0;
  endtask

  function automatic logic [CNT_W-1:0] rd(input int i);
    return rd_cnt[i*CNT_W +: CNT_W];
  endfunction
  function automatic logic [CNT_W-1:0] wr(input int i);
    return wr_cnt[i*CNT_W +: CNT_W];
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int pops0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_instr", instr_cnt, 0);
    chk("rst_rd", rd_cnt, 0);
    chk("rst_wr", wr_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_drop", evt_drop, 0);
    chk("rst_evt_data", evt_data, 0);

    // Window 0 = [0x1000_0040, 0x1000_0100)
    set_win(0, 1, 64'h1000_0040, 64'h1000_0100);
    step(); ar_valid = 1; ar_addr = 64'h1000_0040;
    sb.push_back(mk(0, 0, ar_addr, ts_model));
    @(negedge clk);
    chk("evt_valid_same_cycle", evt_valid, 0);
    chk("rd0_same_cycle", rd(0), 0);
    step(); ar_valid = 0;
    @(negedge clk);
    chk("evt_valid_next_cycle", evt_valid, 1);
    chk("rd0_next_cycle", rd(0), 1);
    step(); ar_valid = 1; ar_addr = 64'h1000_00FF;
    sb.push_back(mk(0, 0, ar_addr, ts_model));
    step(); ar_addr = 64'h1000_0100;
    step(); ar_addr = 64'h1000_0080; ar_ready = 0;
    step(); ar_valid = 0; ar_ready = 1;
    repeat (2) step();
    chk("rd0_count", rd(0), 2);
    chk("sb_empty_t1", sb.size(), 0);

    // Overlap: window 0 inside window 1; window 2 is degenerate.
    do_clr();
    set_win(0, 1, 64'h2000, 64'h2100);
    set_win(1, 1, 64'h1000, 64'h3000);
    set_win(2, 1, 64'h5000, 64'h5000);
    step(); aw_valid = 1; aw_addr = 64'h2000;
    sb.push_back(mk(1, 0, aw_addr, ts_model));
    step(); aw_valid = 0;
    @(negedge clk);
    chk("ovl_wr0", wr(0), 1);
    chk("ovl_wr1", wr(1), 0);
    step(); aw_valid = 1; aw_addr = 64'h1000;
    sb.push_back(mk(1, 1, aw_addr, ts_model));
    step(); aw_valid = 0; ar_valid = 1; ar_addr = 64'h5000;
    step(); ar_valid = 0;
    repeat (2) step();
    chk("ovl_wr1_b", wr(1), 1);
    chk("degenerate_rd2", rd(2), 0);
    chk("ovl_rd_total", rd_cnt, 0);

    // FIFO fill and drop rules.
    do_clr();
    evt_ready = 0;
    for (int i = 0; i < 7; i++) begin
      step(); ar_valid = 1; ar_addr = 64'h2000 + i;
      sb.push_back(mk(0, 0, ar_addr, ts_model));
    end
    step(); ar_addr = 64'h2010; aw_valid = 1; aw_addr = 64'h2020;
    sb.push_back(mk(0, 0, ar_addr, ts_model));
    step(); ar_valid = 0; aw_valid = 0;
    @(negedge clk);
    chk("drop_one", evt_drop, 1);
    chk("full_valid", evt_valid, 1);
    step(); ar_valid = 1; aw_valid = 1;
    step(); ar_valid = 0; aw_valid = 0;
    @(negedge clk);
    chk("drop_both", evt_drop, 3);
    pops0 = n_pops;
    step(); ar_valid = 1; ar_addr = 64'h2030; evt_ready = 1;
    sb.push_back(mk(0, 0, ar_addr, ts_model));
    step(); ar_valid = 0;
    @(negedge clk);
    chk("pushpop_no_drop", evt_drop, 3);
    repeat (10) step();
    chk("drain_pops", n_pops - pops0, 9);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_valid", evt_valid, 0);

    // Watchdog.
    do_clr();
    step(); to_limit = 5;
    for (int k = 1; k <= 5; k++) step();
    @(negedge clk);
    chk("wd_before_expiry", timeout, 0);
    step(); @(negedge clk);
    chk("wd_expired", timeout, 1);
    repeat (3) step();
    chk("wd_sticky", timeout, 1);
    step(); clr = 1;
    step(); clr = 0;
    @(negedge clk);
    chk("wd_clr", timeout, 0);
    repeat (4) step();
    retire = 1;
    step(); retire = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wd_retire_saves", timeout, 0);
      step();
    end
    @(negedge clk);
    chk("wd_fresh_expiry", timeout, 1);
    step(); to_limit = 0;
    do_clr();
    repeat (8) step();
    chk("wd_disabled", timeout, 0);

    // Retire counting and saturation.
    do_clr();
    retire = 1;
    repeat (100) step();
    retire = 0;
    @(negedge clk);
    chk("instr_100", instr_cnt, 100);
    chk("small_instr_100", s_instr, 100);
    step(); clr = 1; retire = 1;
    step(); clr = 0; retire = 0;
    @(negedge clk);
    chk("clr_beats_retire", instr_cnt, 0);
    retire = 1;
    repeat (300) step();
    retire = 0;
    @(negedge clk);
    chk("instr_300", instr_cnt, 300);
    chk("small_instr_sat", s_instr, 255);

    // Asynchronous reset with a full FIFO mid-burst.
    do_clr();
    evt_ready = 0;
    set_win(0, 1, 64'h2000, 64'h2100);
    for (int i = 0; i < 9; i++) begin
      step(); ar_valid = 1; ar_addr = 64'h2040 + i;
      if (i < 8) sb.push_back(mk(0, 0, ar_addr, ts_model));
    end
    step();
    #2 rst_n = 0;
    sb.delete();
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_rd", rd_cnt, 0);
    chk("arst_drop", evt_drop, 0);
    chk("arst_instr", instr_cnt, 0);
    chk("arst_data", evt_data, 0);
    ar_valid = 0;
    step(); rst_n = 1; evt_ready = 1;
    step(); ar_valid = 1; ar_addr = 64'h2050;
    sb.push_back(mk(0, 0, ar_addr, ts_model));
    step(); ar_valid = 0;
    repeat (3) step();
    chk("resume_rd0", rd(0), 1);
    chk("resume_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
